// File: rtl/fighter_pkg.sv
// Shared types and default frame/position constants for the fighter action sequencer
// and the blocks that consume its outputs.
package fighter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK_L  = 3'd1,
    ST_WALK_R  = 3'd2,
    ST_PUNCH   = 3'd3,
    ST_KICK    = 3'd4,
    ST_BLOCK   = 3'd5,
    ST_HITSTUN = 3'd6
  } action_e;

  localparam int unsigned DEF_PUNCH_STARTUP  = 3;
  localparam int unsigned DEF_PUNCH_ACTIVE   = 2;
  localparam int unsigned DEF_PUNCH_RECOVERY = 4;
  localparam int unsigned DEF_KICK_STARTUP   = 5;
  localparam int unsigned DEF_KICK_ACTIVE    = 3;
  localparam int unsigned DEF_KICK_RECOVERY  = 6;
  localparam int unsigned DEF_HITSTUN        = 8;
  localparam int unsigned DEF_WALK_STEP      = 4;
  localparam int unsigned DEF_KNOCKBACK      = 2;
  localparam int unsigned DEF_X_MIN          = 0;
  localparam int unsigned DEF_X_MAX          = 560;
  localparam int unsigned DEF_X_INIT         = 100;
  localparam int unsigned DEF_X_W            = 10;

  // Button arbitration for the free states: attacks win over block, block over walking,
  // and opposing directions cancel out.
  function automatic action_e pick_action(input logic left, input logic right,
                                          input logic punch, input logic kick,
                                          input logic block);
    if (punch)               return ST_PUNCH;
    else if (kick)           return ST_KICK;
    else if (block)          return ST_BLOCK;
    else if (left && !right) return ST_WALK_L;
    else if (right && !left) return ST_WALK_R;
    else                     return ST_IDLE;
  endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Turns the slowed frame clock level into a one-cycle tick in the system clock domain.
// Also used by the round timer.
module frame_tick_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic frame_clk,
  output logic tick,
  output logic frame_tick
);

  logic fc_q;

  // fc_q resets high so a frame clock already high at reset release is not an edge.
  assign tick = frame_clk & ~fc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      fc_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      fc_q       <= frame_clk;
      frame_tick <= tick;
    end
  end

endmodule

// File: rtl/fighter_action_fsm.sv
// Per-fighter action sequencer: advances action state, animation frame and x position
// once per frame tick.
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter int unsigned PUNCH_STARTUP  = DEF_PUNCH_STARTUP,
  parameter int unsigned PUNCH_ACTIVE   = DEF_PUNCH_ACTIVE,
  parameter int unsigned PUNCH_RECOVERY = DEF_PUNCH_RECOVERY,
  parameter int unsigned KICK_STARTUP   = DEF_KICK_STARTUP,
  parameter int unsigned KICK_ACTIVE    = DEF_KICK_ACTIVE,
  parameter int unsigned KICK_RECOVERY  = DEF_KICK_RECOVERY,
  parameter int unsigned HITSTUN        = DEF_HITSTUN,
  parameter int unsigned WALK_STEP      = DEF_WALK_STEP,
  parameter int unsigned KNOCKBACK      = DEF_KNOCKBACK,
  parameter int unsigned X_MIN          = DEF_X_MIN,
  parameter int unsigned X_MAX          = DEF_X_MAX,
  parameter int unsigned X_INIT         = DEF_X_INIT,
  parameter int unsigned X_W            = DEF_X_W
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           frame_clk,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_punch,
  input  logic           btn_kick,
  input  logic           btn_block,
  input  logic           facing_right,
  input  logic           hit_in,
  output logic           frame_tick,
  output action_e        state,
  output logic [3:0]     frame_idx,
  output logic [X_W-1:0] pos_x,
  output logic           attack_active,
  output logic           blocking
);

  localparam int unsigned PUNCH_TOTAL = PUNCH_STARTUP + PUNCH_ACTIVE + PUNCH_RECOVERY;
  localparam int unsigned KICK_TOTAL  = KICK_STARTUP + KICK_ACTIVE + KICK_RECOVERY;

  localparam logic [3:0] PUNCH_LAST = 4'(PUNCH_TOTAL - 1);
  localparam logic [3:0] KICK_LAST  = 4'(KICK_TOTAL - 1);
  localparam logic [3:0] HIT_LAST   = 4'(HITSTUN - 1);
  localparam logic [3:0] PUNCH_LO   = 4'(PUNCH_STARTUP);
  localparam logic [3:0] PUNCH_HI   = 4'(PUNCH_STARTUP + PUNCH_ACTIVE - 1);
  localparam logic [3:0] KICK_LO    = 4'(KICK_STARTUP);
  localparam logic [3:0] KICK_HI    = 4'(KICK_STARTUP + KICK_ACTIVE - 1);

  localparam logic [X_W-1:0] POS_MIN  = X_W'(X_MIN);
  localparam logic [X_W-1:0] POS_MAX  = X_W'(X_MAX);
  localparam logic [X_W-1:0] POS_INIT = X_W'(X_INIT);
  localparam logic [X_W-1:0] STEP     = X_W'(WALK_STEP);
  localparam logic [X_W-1:0] KNOCK    = X_W'(KNOCKBACK);

  // Distance to the limit is compared before moving so the position never wraps.
  function automatic logic [X_W-1:0] move_left(input logic [X_W-1:0] p,
                                               input logic [X_W-1:0] d);
    return ((p - POS_MIN) < d) ? POS_MIN : p - d;
  endfunction

  function automatic logic [X_W-1:0] move_right(input logic [X_W-1:0] p,
                                                input logic [X_W-1:0] d);
    return ((POS_MAX - p) < d) ? POS_MAX : p + d;
  endfunction

  logic           tick;
  logic           hit_any;
  logic           timed;
  logic [3:0]     last_idx;

  action_e        state_q, state_n;
  logic [3:0]     idx_q, idx_n;
  logic [X_W-1:0] pos_q, pos_n;
  logic           hit_q, hit_n;
  logic           atk_q, atk_n;
  logic           blk_q, blk_n;

  frame_tick_detect u_tick (
    .clk_in     (clk_in),
    .rst        (rst),
    .frame_clk  (frame_clk),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  // A hit arriving in the tick cycle itself is consumed by that tick.
  assign hit_any = hit_q | hit_in;
  assign timed   = (state_q == ST_PUNCH) || (state_q == ST_KICK) || (state_q == ST_HITSTUN);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n  = state_q;
    idx_n    = idx_q;
    pos_n    = pos_q;
    hit_n    = hit_q;
    last_idx = HIT_LAST;

    case (state_q)
      ST_PUNCH: last_idx = PUNCH_LAST;
      ST_KICK:  last_idx = KICK_LAST;
      default:  last_idx = HIT_LAST;
    endcase

    if (tick) begin
      hit_n = 1'b0;

      // Movement belongs to the state being left, not the one being entered.
      case (state_q)
        ST_WALK_L:  pos_n = move_left(pos_q, STEP);
        ST_WALK_R:  pos_n = move_right(pos_q, STEP);
        ST_HITSTUN: pos_n = facing_right ? move_left(pos_q, KNOCK) : move_right(pos_q, KNOCK);
        default:    pos_n = pos_q;
      endcase

      if (hit_any && state_q != ST_BLOCK) begin
        state_n = ST_HITSTUN;
        idx_n   = '0;
      end else if (hit_any) begin
        idx_n = idx_q + 4'd1;
      end else if (timed) begin
        if (idx_q == last_idx) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + 4'd1;
        end
      end else begin
        state_n = pick_action(btn_left, btn_right, btn_punch, btn_kick, btn_block);
        idx_n   = (state_n == state_q) ? idx_q + 4'd1 : 4'd0;
      end
    end else if (hit_in) begin
      hit_n = 1'b1;
    end

    atk_n = ((state_n == ST_PUNCH) && (idx_n >= PUNCH_LO) && (idx_n <= PUNCH_HI)) ||
            ((state_n == ST_KICK)  && (idx_n >= KICK_LO)  && (idx_n <= KICK_HI));
    blk_n = (state_n == ST_BLOCK);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pos_q   <= POS_INIT;
      hit_q   <= 1'b0;
      atk_q   <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      pos_q   <= pos_n;
      hit_q   <= hit_n;
      atk_q   <= atk_n;
      blk_q   <= blk_n;
    end
  end

  assign state         = state_q;
  assign frame_idx     = idx_q;
  assign pos_x         = pos_q;
  assign attack_active = atk_q;
  assign blocking      = blk_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Randomized scoreboard bench for fighter_action_fsm: a frame-level reference model
// predicts each tick's outputs, a monitor compares them whenever frame_tick appears.
module tb_fighter_action_fsm;
  import fighter_pkg::*;

  logic       clk_in;
  logic       rst;
  logic       frame_clk;
  logic       btn_left, btn_right, btn_punch, btn_kick, btn_block;
  logic       facing_right;
  logic       hit_in;
  logic       frame_tick;
  action_e    state;
  logic [3:0] frame_idx;
  logic [9:0] pos_x;
  logic       attack_active;
  logic       blocking;

  fighter_action_fsm dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .frame_clk     (frame_clk),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_punch     (btn_punch),
    .btn_kick      (btn_kick),
    .btn_block     (btn_block),
    .facing_right  (facing_right),
    .hit_in        (hit_in),
    .frame_tick    (frame_tick),
    .state         (state),
    .frame_idx     (frame_idx),
    .pos_x         (pos_x),
    .attack_active (attack_active),
    .blocking      (blocking)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int st;
    int idx;
    int pos;
    int atk;
    int blk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Frame-level reference: plain integers, spec numbers written out directly.
  int   m_state, m_idx, m_pos;
  bit   m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = int'(ST_IDLE);
    m_idx   = 0;
    m_pos   = 100;
    m_pend  = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit p, input bit k, input bit b,
                            input bit fr, input bit hit_now);
    bit   hit;
    int   old;
    int   len;
    int   nxt;
    exp_t e;
    hit = m_pend || hit_now;
    old = m_state;
    if (old == int'(ST_WALK_L))       m_pos = (m_pos < 4) ? 0 : m_pos - 4;
    else if (old == int'(ST_WALK_R))  m_pos = (m_pos + 4 > 560) ? 560 : m_pos + 4;
    else if (old == int'(ST_HITSTUN)) m_pos = fr ? ((m_pos < 2) ? 0 : m_pos - 2)
                                                 : ((m_pos + 2 > 560) ? 560 : m_pos + 2);
    if (hit && old != int'(ST_BLOCK)) begin
      m_state = int'(ST_HITSTUN);
      m_idx   = 0;
    end else if (hit) begin
      m_idx = (m_idx + 1) % 16;
    end else if (old == int'(ST_PUNCH) || old == int'(ST_KICK) || old == int'(ST_HITSTUN)) begin
      len = (old == int'(ST_PUNCH)) ? 9 : (old == int'(ST_KICK)) ? 14 : 8;
      if (m_idx == len - 1) begin
        m_state = int'(ST_IDLE);
        m_idx   = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end else begin
      if (p)               nxt = int'(ST_PUNCH);
      else if (k)          nxt = int'(ST_KICK);
      else if (b)          nxt = int'(ST_BLOCK);
      else if (l && !r)    nxt = int'(ST_WALK_L);
      else if (r && !l)    nxt = int'(ST_WALK_R);
      else                 nxt = int'(ST_IDLE);
      m_idx   = (nxt == old) ? (m_idx + 1) % 16 : 0;
      m_state = nxt;
    end
    m_pend = 0;
    e.st  = m_state;
    e.idx = m_idx;
    e.pos = m_pos;
    e.atk = ((m_state == int'(ST_PUNCH)) && m_idx >= 3 && m_idx <= 4) ||
            ((m_state == int'(ST_KICK))  && m_idx >= 5 && m_idx <= 7) ? 1 : 0;
    e.blk = (m_state == int'(ST_BLOCK)) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic rand_buttons();
    btn_left  = 1'($urandom_range(0, 1));
    btn_right = 1'($urandom_range(0, 1));
    btn_punch = 1'($urandom_range(0, 1));
    btn_kick  = 1'($urandom_range(0, 1));
    btn_block = 1'($urandom_range(0, 1));
  endtask

  // One frame: a low phase with junk buttons (must be ignored), then a rising edge
  // carrying the real button levels, then a short high phase.
  task automatic frame(input bit l, input bit r, input bit p, input bit k, input bit b,
                       input bit fr, input bit hit_mid, input bit hit_tick);
    int low_n;
    int high_n;
    low_n  = $urandom_range(1, 3);
    high_n = $urandom_range(1, 2);
    facing_right = fr;
    for (int i = 0; i < low_n; i++) begin
      @(negedge clk_in);
      frame_clk = 1'b0;
      rand_buttons();
      hit_in = (hit_mid && i == 0);
      if (hit_in) m_pend = 1;
    end
    @(negedge clk_in);
    frame_clk = 1'b1;
    btn_left  = l;
    btn_right = r;
    btn_punch = p;
    btn_kick  = k;
    btn_block = b;
    hit_in    = hit_tick;
    model_tick(l, r, p, k, b, fr, hit_tick);
    for (int i = 0; i < high_n; i++) begin
      @(negedge clk_in);
      hit_in = 1'b0;
      rand_buttons();
    end
  endtask

  task automatic idle_frames(input int n, input bit fr);
    for (int i = 0; i < n; i++) frame(0, 0, 0, 0, 0, fr, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_in);
  endtask

  // Monitor: every frame_tick pops one expectation; ticks must be one cycle wide.
  bit prev_tick = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (frame_tick === 1'b1) begin
        check("tick_width", 32'(prev_tick), 0);
        if (sb.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          e = sb.pop_front();
          check("state", 32'(state), 32'(e.st));
          check("frame_idx", 32'(frame_idx), 32'(e.idx));
          check("pos_x", 32'(pos_x), 32'(e.pos));
          check("attack_active", 32'(attack_active), 32'(e.atk));
          check("blocking", 32'(blocking), 32'(e.blk));
        end
      end
      prev_tick = (frame_tick === 1'b1);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks_seen;
    rst = 1'b1; frame_clk = 1'b1; hit_in = 1'b0; facing_right = 1'b0;
    btn_left = 0; btn_right = 0; btn_punch = 0; btn_kick = 0; btn_block = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_idx", 32'(frame_idx), 0);
    check("rst_pos", 32'(pos_x), 100);
    check("rst_attack", 32'(attack_active), 0);
    check("rst_blocking", 32'(blocking), 0);
    check("rst_tick", 32'(frame_tick), 0);

    // Frame clock held high through release: no tick may appear.
    rst = 1'b0;
    ticks_seen = 0;
    repeat (4) begin
      @(negedge clk_in);
      if (frame_tick === 1'b1) ticks_seen++;
    end
    check("no_tick_at_release", 32'(ticks_seen), 0);

    // First real edge, then a full punch.
    idle_frames(1, 0);
    frame(0, 0, 1, 0, 0, 0, 0, 0);
    idle_frames(10, 0);

    // Double hit: restarted hitstun leaves pos at 102, then 8 frames of knockback -> 118.
    frame(0, 0, 0, 0, 0, 0, 1, 0);
    frame(0, 0, 0, 0, 0, 0, 1, 0);
    idle_frames(9, 0);

    // Walk left through 2 down to the X_MIN clamp, then left+right together.
    for (int i = 0; i < 34; i++) frame(1, 0, 0, 0, 0, 0, 0, 0);
    frame(1, 1, 0, 0, 0, 0, 0, 0);
    frame(1, 1, 0, 0, 0, 0, 0, 0);

    // Knock back to 18, then walk right through 558 into the X_MAX clamp.
    frame(0, 0, 0, 0, 0, 0, 1, 0);
    frame(0, 0, 0, 0, 0, 0, 1, 0);
    idle_frames(9, 0);
    for (int i = 0; i < 140; i++) frame(0, 1, 0, 0, 0, 0, 0, 0);
    idle_frames(1, 1);

    // Kick interrupted by a hit during its active frames, facing right.
    frame(0, 0, 0, 1, 0, 1, 0, 0);
    idle_frames(5, 1);
    frame(0, 0, 0, 0, 0, 1, 1, 0);
    idle_frames(9, 1);

    // Blocked hits (between ticks and on the tick), then the latch must be clear.
    frame(0, 0, 0, 0, 1, 1, 0, 0);
    frame(0, 0, 0, 0, 1, 1, 1, 0);
    frame(0, 0, 0, 0, 0, 1, 0, 1);
    idle_frames(2, 1);

    // Hit in the same cycle as the tick.
    frame(0, 0, 0, 0, 0, 0, 0, 1);
    idle_frames(9, 0);

    // Reset arriving together with a tick in the middle of a punch.
    frame(0, 0, 1, 0, 0, 0, 0, 0);
    idle_frames(3, 0);
    drain();
    @(negedge clk_in);
    frame_clk = 1'b0;
    @(negedge clk_in);
    frame_clk = 1'b1;
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    check("rst_tick_state", 32'(state), 32'(ST_IDLE));
    check("rst_tick_idx", 32'(frame_idx), 0);
    check("rst_tick_pos", 32'(pos_x), 100);
    check("rst_tick_attack", 32'(attack_active), 0);
    check("rst_tick_frame_tick", 32'(frame_tick), 0);
    model_reset();
    repeat (3) @(negedge clk_in);

    // Randomized frames.
    for (int i = 0; i < 200; i++) begin
      frame(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    drain();
    repeat (2) @(negedge clk_in);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fighter_action_fsm.md
# fighter_action_fsm

Per-fighter action sequencer for the street-fighter game. It consumes the slowed frame clock produced by the clock divider and converts its rising edges into single-cycle frame ticks in the 100 MHz domain. On each tick it advances one fighter's action state machine (idle, walk, punch, kick, block, hitstun), its animation frame index and its horizontal position. Its outputs feed the sprite renderer and the collision checker.

## Interface
- `PUNCH_STARTUP`, 3: punch startup frames
- `PUNCH_ACTIVE`, 2: punch active (hitbox) frames
- `PUNCH_RECOVERY`, 4: punch recovery frames
- `KICK_STARTUP`, 5 / `KICK_ACTIVE`, 3 / `KICK_RECOVERY`, 6: kick phase lengths, in frames
- `HITSTUN`, 8: hitstun length in frames (at least 1)
- `WALK_STEP`, 4: pixels moved per walk frame
- `KNOCKBACK`, 2: pixels pushed per hitstun frame
- `X_MIN`, 0 / `X_MAX`, 560 / `X_INIT`, 100: position limits and reset position
- `X_W`, 10: position width
- `clk_in`  in  1  100 MHz system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `frame_clk`  in  1  slowed clock level, registered in the `clk_in` domain (no synchronizer needed)
- `btn_left`, `btn_right`, `btn_punch`, `btn_kick`, `btn_block`  in  1 each  debounced level inputs
- `facing_right`  in  1  fighter orientation; sets knockback direction
- `hit_in`  in  1  single-cycle pulse from the collision checker
- `frame_tick`  out  1  one-cycle pulse per frame
- `state`  out  3  current action (encoding in the package)
- `frame_idx`  out  4  animation frame within the current action
- `pos_x`  out  X_W  fighter x position
- `attack_active`  out  1  hitbox live
- `blocking`  out  1  high while in BLOCK

## Operation
- **Edge detect:** `fc_q <= frame_clk`. `tick_c = frame_clk & ~fc_q`. On reset, `fc_q` is set to 1, so a `frame_clk` that is high at reset release does not produce a tick.
- **Hit latch:** `hit_in` sets `hit_pending`. The latch clears on the tick that consumes it. If `hit_in` and `tick_c` occur in the same cycle, the hit counts for that tick.
- **Next state, evaluated only on `tick_c`, in priority order:**
  1. `hit_pending` and state is not BLOCK: go to HITSTUN with `frame_idx` = 0. This interrupts attacks and restarts a running hitstun.
  2. `hit_pending` and state is BLOCK: the hit is absorbed. Clear the latch and stay in BLOCK.
  3. PUNCH, KICK or HITSTUN, not yet at the last frame: stay, `frame_idx`+1.
  4. At the last frame (`frame_idx` == total−1): go to IDLE. Inputs are evaluated at the following tick.
  5. From IDLE, WALK_L, WALK_R or BLOCK, take the first of: punch → PUNCH; kick → KICK; block → BLOCK; left only → WALK_L; right only → WALK_R; otherwise (including left and right together) → IDLE.
- **frame_idx:** resets to 0 on any state change. Otherwise it increments and wraps mod 16 in IDLE, WALK and BLOCK.
- **Position, updated on the tick:**
  - WALK_L: `pos_x − WALK_STEP`, saturating at X_MIN. Compare before subtracting; no underflow wrap.
  - WALK_R: `pos_x + WALK_STEP`, saturating at X_MAX.
  - HITSTUN: moves KNOCKBACK away from the opponent (decrease if `facing_right`), with the same saturation.
  - All other states: hold.
  - The move uses the state being exited, not the state being entered.
- **attack_active:** high in PUNCH/KICK when `frame_idx` is in [STARTUP, STARTUP+ACTIVE−1].
- **blocking:** equals (`state` == BLOCK).

## Timing
- Cycle N is the cycle where `tick_c` = 1. At the end of cycle N, `state`, `frame_idx`, `pos_x` and `hit_pending` update, and `frame_tick` is registered high for cycle N+1 only.
- All outputs are registered. The frame-level latency from a button press to the state change is up to one frame.
- Button levels are sampled only in tick cycles; presses between ticks are ignored.
- `rst` has priority over everything, including a tick in the same cycle. Reset values:
  - `state` = IDLE, `frame_idx` = 0, `pos_x` = X_INIT
  - `frame_tick`, `attack_active`, `blocking`, `hit_pending` = 0
- A reset in the middle of an attack abandons the attack.

## Structure
- Package `fighter_pkg` holds:
  - the state encodings (IDLE = 0, WALK_L = 1, WALK_R = 2, PUNCH = 3, KICK = 4, BLOCK = 5, HITSTUN = 6)
  - the default frame-length constants
- Sub-module `frame_tick_detect` contains the `fc_q` register and the one-cycle `frame_tick` register. It is reused by the round timer.
- Attack totals are computed as localparams.

## Test plan
- **Reset and first edge:** hold `frame_clk` = 1 through reset release → no `frame_tick`. A later 0→1 edge → exactly one `frame_tick`, one cycle wide.
- **Punch sequence:** press punch for one tick → state = PUNCH for 9 ticks, `attack_active` high at `frame_idx` 3–4 only, then IDLE.
- **Walk saturation:** `pos_x` = 2 with `btn_left` held → 0 and stays 0. `pos_x` = 558 with `btn_right` held → 560. Left and right held together → IDLE, position unchanged.
- **Hit interrupts kick:** `hit_in` during the kick active frames → HITSTUN at the next tick. With `facing_right` = 1, `pos_x` decreases by 2 per frame for 8 frames, then IDLE.
- **Blocked hit:** while in BLOCK, pulse `hit_in` → state stays BLOCK, `pos_x` unchanged, latch cleared.
- **Simultaneous events:** `hit_in` in the same cycle as `tick_c` → HITSTUN taken on that tick. `rst` in the same cycle as a tick → all reset values.
